// File: rtl/time_keeper_12h_pkg.sv
// clock_pkg: shared constants and types for the 12-hour time keeper.
// Also adopted by the alarm block so field codes and widths stay in step.
//   TIME_W              width of hour/minute/second fields
//   HOUR_MAX/MIN_MAX/SEC_MAX  last legal value of each field
//   sel_field_e         set-mode field select (hour, minute, AM/PM)
//   next_field()        set-mode field rotation 0->1->2->0
//   wrap_inc()          +1 with wrap to 0 after a given maximum
package clock_pkg;

  localparam int TIME_W = 6;

  localparam logic [TIME_W-1:0] HOUR_MAX = 6'd11;
  localparam logic [TIME_W-1:0] MIN_MAX  = 6'd59;
  localparam logic [TIME_W-1:0] SEC_MAX  = 6'd59;

  typedef enum logic [1:0] {
    SEL_HOUR = 2'd0,
    SEL_MIN  = 2'd1,
    SEL_AMPM = 2'd2
  } sel_field_e;

  // Code 3 is unreachable; it falls back to SEL_HOUR.
  function automatic sel_field_e next_field(input sel_field_e f);
    case (f)
      SEL_HOUR: next_field = SEL_MIN;
      SEL_MIN:  next_field = SEL_AMPM;
      default:  next_field = SEL_HOUR;
    endcase
  endfunction

  function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] v,
                                                 input logic [TIME_W-1:0] max_v);
    wrap_inc = (v == max_v) ? '0 : v + TIME_W'(1);
  endfunction

endpackage

// File: rtl/time_keeper_12h_if.sv
// time_keeper_12h_if: user controls and time outputs of the time keeper.
// Handshake: there is no valid/ready pair. set_mode is a level; sel and inc
// are sampled every clock and each high cycle is one step. All outputs are
// registered and valid every cycle.
//   set_mode, sel, inc   controls (driven by master)
//   hour, min, sec       current time fields
//   am_pm                0 = AM, 1 = PM
//   set_field            field selected in set mode (also the set-mode state)
//   sec_tick             one-cycle pulse per counted second
//   chime                hourly pulse (zero unless TIME_KEEPER_CHIME_EN)
// Modports: master = controller/testbench, slave = time keeper.
interface time_keeper_12h_if;
  import clock_pkg::*;

  logic              set_mode;
  logic              sel;
  logic              inc;
  logic [TIME_W-1:0] hour;
  logic [TIME_W-1:0] min;
  logic [TIME_W-1:0] sec;
  logic              am_pm;
  logic [1:0]        set_field;
  logic              sec_tick;
  logic              chime;

  modport master (
    output set_mode, sel, inc,
    input  hour, min, sec, am_pm, set_field, sec_tick, chime
  );

  modport slave (
    input  set_mode, sel, inc,
    output hour, min, sec, am_pm, set_field, sec_tick, chime
  );

endinterface

// File: rtl/time_keeper_12h_sec_prescaler.sv
// sec_prescaler: divides clk down to a one-second tick.
//   clk   system clock
//   rst   synchronous active-high reset, count -> 0
//   clr   holds the count at 0 (set mode)
//   tick  combinational, high while count == TICK_DIV-1 and clr is low;
//         the count wraps to 0 on the same edge
module sec_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int                CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign tick = (r_count == LAST) && !clr;

endmodule

// File: rtl/time_keeper_12h.sv
// time_keeper_12h: free-running 12-hour wall clock (hour 0-11 + AM/PM,
// minute, second) with a set mode for hour, minute and AM/PM.
//   clk        system clock
//   rst        synchronous reset, active-high, priority over everything
//   tk         time_keeper_12h_if.slave (controls in, time/status out)
// Parameter TICK_DIV: clk cycles per second (>= 2).
// Optional macro TIME_KEEPER_CHIME_EN: when defined, chime pulses with the
// sec_tick of every counted step that lands on mm:ss = 00:00. When undefined
// chime is tied low.
module time_keeper_12h
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  time_keeper_12h_if.slave  tk
);

  logic              w_tick;

  logic [TIME_W-1:0] r_hour;
  logic [TIME_W-1:0] r_min;
  logic [TIME_W-1:0] r_sec;
  logic              r_am_pm;
  sel_field_e        r_set_field;
  logic              r_sec_tick;

  // Counted-step successor of the current time (full carry chain).
  logic [TIME_W-1:0] w_sec_nxt;
  logic [TIME_W-1:0] w_min_nxt;
  logic [TIME_W-1:0] w_hour_nxt;
  logic              w_am_pm_nxt;

  // The prescaler is held at 0 throughout set mode, so counting restarts a
  // full second after set_mode falls.
  sec_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (tk.set_mode),
    .tick (w_tick)
  );

  always_comb begin
    w_sec_nxt   = r_sec + TIME_W'(1);
    w_min_nxt   = r_min;
    w_hour_nxt  = r_hour;
    w_am_pm_nxt = r_am_pm;
    if (r_sec == SEC_MAX) begin
      w_sec_nxt = '0;
      w_min_nxt = r_min + TIME_W'(1);
      if (r_min == MIN_MAX) begin
        w_min_nxt  = '0;
        w_hour_nxt = r_hour + TIME_W'(1);
        if (r_hour == HOUR_MAX) begin
          w_hour_nxt  = '0;
          w_am_pm_nxt = ~r_am_pm;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hour      <= '0;
      r_min       <= '0;
      r_sec       <= '0;
      r_am_pm     <= 1'b0;
      r_set_field <= SEL_HOUR;
      r_sec_tick  <= 1'b0;
    end else if (tk.set_mode) begin
      r_sec      <= '0;
      r_sec_tick <= 1'b0;
      // inc edits the field selected before this edge; edits never carry.
      if (tk.inc) begin
        case (r_set_field)
          SEL_HOUR: r_hour  <= wrap_inc(r_hour, HOUR_MAX);
          SEL_MIN:  r_min   <= wrap_inc(r_min, MIN_MAX);
          SEL_AMPM: r_am_pm <= ~r_am_pm;
          default:  ;
        endcase
      end
      if (tk.sel) begin
        r_set_field <= next_field(r_set_field);
      end
    end else begin
      r_set_field <= SEL_HOUR;
      r_sec_tick  <= w_tick;
      if (w_tick) begin
        r_sec   <= w_sec_nxt;
        r_min   <= w_min_nxt;
        r_hour  <= w_hour_nxt;
        r_am_pm <= w_am_pm_nxt;
      end
    end
  end

`ifdef TIME_KEEPER_CHIME_EN
  logic r_chime;

  always_ff @(posedge clk) begin
    if (rst || tk.set_mode) begin
      r_chime <= 1'b0;
    end else begin
      r_chime <= w_tick && (w_sec_nxt == '0) && (w_min_nxt == '0);
    end
  end

  assign tk.chime = r_chime;
`else
  assign tk.chime = 1'b0;
`endif

  assign tk.hour      = r_hour;
  assign tk.min       = r_min;
  assign tk.sec       = r_sec;
  assign tk.am_pm     = r_am_pm;
  assign tk.set_field = r_set_field;
  assign tk.sec_tick  = r_sec_tick;

endmodule

// File: tb/tb_time_keeper_12h.sv
// Testbench for time_keeper_12h with TICK_DIV = 4.
module tb_time_keeper_12h;

  localparam int TD = 4;
`ifdef TIME_KEEPER_CHIME_EN
  localparam bit CHIME_EN = 1'b1;
`else
  localparam bit CHIME_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  time_keeper_12h_if tk_if ();

  time_keeper_12h #(
    .TICK_DIV (TD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .tk  (tk_if)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  int m_hour, m_min, m_sec, m_ampm;

  typedef struct {
    int sm, sel, inc;
    int e_hour, e_min, e_sec, e_ampm, e_field, e_tick;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the edge; outputs are then stable.
  task automatic step(input logic sm, input logic s, input logic i);
    tk_if.set_mode = sm;
    tk_if.sel      = s;
    tk_if.inc      = i;
    @(posedge clk);
    #1;
  endtask

  task automatic set_inc_n(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b1);
  endtask

  task automatic chk_time(input string name, input int h, input int m, input int s,
                          input int ap);
    chk({name, " hour"}, int'(tk_if.hour), h);
    chk({name, " min"}, int'(tk_if.min), m);
    chk({name, " sec"}, int'(tk_if.sec), s);
    chk({name, " am_pm"}, int'(tk_if.am_pm), ap);
  endtask

  task automatic chk_reset(input string name);
    chk_time(name, 0, 0, 0, 0);
    chk({name, " set_field"}, int'(tk_if.set_field), 0);
    chk({name, " sec_tick"}, int'(tk_if.sec_tick), 0);
    chk({name, " chime"}, int'(tk_if.chime), 0);
  endtask

  task automatic model_tick();
    m_sec++;
    if (m_sec == 60) begin
      m_sec = 0;
      m_min++;
      if (m_min == 60) begin
        m_min = 0;
        m_hour++;
        if (m_hour == 12) begin
          m_hour = 0;
          m_ampm = 1 - m_ampm;
        end
      end
    end
  endtask

  // Runs n seconds from prescaler==0 with random sel/inc (must be ignored).
  task automatic run_ticks(input int n, input string tag);
    int exp_chime;
    for (int t = 0; t < n; t++) begin
      for (int c = 0; c < TD - 1; c++) begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk({tag, " tick low"}, int'(tk_if.sec_tick), 0);
        chk({tag, " chime low"}, int'(tk_if.chime), 0);
        chk({tag, " field idle"}, int'(tk_if.set_field), 0);
      end
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      model_tick();
      exp_chime = (CHIME_EN && m_min == 0 && m_sec == 0) ? 1 : 0;
      chk({tag, " tick high"}, int'(tk_if.sec_tick), 1);
      chk({tag, " chime"}, int'(tk_if.chime), exp_chime);
      chk_time(tag, m_hour, m_min, m_sec, m_ampm);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tk_if.set_mode = 1'b0;
    tk_if.sel      = 1'b0;
    tk_if.inc      = 1'b0;

    // Reset with sel/inc held high: reset wins.
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk_reset("reset");
    rst = 1'b0;

    // 1: ticks every 4 cycles from reset release.
    for (int c = 1; c <= 12; c++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("t1 tick", int'(tk_if.sec_tick), (c % 4 == 0) ? 1 : 0);
      if (c % 4 == 0) chk("t1 sec", int'(tk_if.sec), c / 4);
    end
    chk_time("t1 end", 0, 0, 3, 0);

    // 2: set 11:59 AM and roll to 00:00:00 PM.
    step(1'b1, 1'b0, 1'b0);
    chk("t2 sec forced", int'(tk_if.sec), 0);
    chk("t2 tick off", int'(tk_if.sec_tick), 0);
    step(1'b1, 1'b1, 1'b0);
    chk("t2 field min", int'(tk_if.set_field), 1);
    set_inc_n(59);
    step(1'b1, 1'b1, 1'b0);
    chk("t2 field ampm", int'(tk_if.set_field), 2);
    step(1'b1, 1'b1, 1'b0);
    chk("t2 field wrap", int'(tk_if.set_field), 0);
    set_inc_n(11);
    chk_time("t2 set", 11, 59, 0, 0);
    m_hour = 11; m_min = 59; m_sec = 0; m_ampm = 0;
    run_ticks(60, "t2 am2pm");
    chk("t2 pm", int'(tk_if.am_pm), 1);

    // Set 11:59 PM and roll to 00:00:00 AM.
    step(1'b1, 1'b0, 1'b0);
    set_inc_n(11);
    step(1'b1, 1'b1, 1'b0);
    set_inc_n(59);
    chk_time("t2 set pm", 11, 59, 0, 1);
    m_hour = 11; m_min = 59; m_sec = 0; m_ampm = 1;
    run_ticks(60, "t2 pm2am");

    // 4 and leave-set behaviour: table from 00:00:00 AM, field 0, prescaler 0.
    vt[0]  = '{1, 0, 1, 1, 0, 0, 0, 0, 0};
    vt[1]  = '{1, 1, 1, 2, 0, 0, 0, 1, 0};
    vt[2]  = '{1, 0, 1, 2, 1, 0, 0, 1, 0};
    vt[3]  = '{1, 1, 0, 2, 1, 0, 0, 2, 0};
    vt[4]  = '{1, 1, 1, 2, 1, 0, 1, 0, 0};
    vt[5]  = '{1, 0, 1, 3, 1, 0, 1, 0, 0};
    vt[6]  = '{1, 1, 0, 3, 1, 0, 1, 1, 0};
    vt[7]  = '{1, 1, 0, 3, 1, 0, 1, 2, 0};
    vt[8]  = '{1, 0, 1, 3, 1, 0, 0, 2, 0};
    vt[9]  = '{1, 0, 0, 3, 1, 0, 0, 2, 0};
    vt[10] = '{0, 1, 1, 3, 1, 0, 0, 0, 0};
    vt[11] = '{0, 1, 1, 3, 1, 0, 0, 0, 0};
    vt[12] = '{0, 0, 1, 3, 1, 0, 0, 0, 0};
    vt[13] = '{0, 1, 0, 3, 1, 1, 0, 0, 1};
    for (int v = 0; v < 14; v++) begin
      step(1'(vt[v].sm), 1'(vt[v].sel), 1'(vt[v].inc));
      chk_time($sformatf("tbl%0d", v), vt[v].e_hour, vt[v].e_min, vt[v].e_sec,
               vt[v].e_ampm);
      chk($sformatf("tbl%0d field", v), int'(tk_if.set_field), vt[v].e_field);
      chk($sformatf("tbl%0d tick", v), int'(tk_if.sec_tick), vt[v].e_tick);
      chk($sformatf("tbl%0d chime", v), int'(tk_if.chime), 0);
    end

    // 3: edit wraps do not carry.
    step(1'b1, 1'b0, 1'b0);
    set_inc_n(8);
    chk("t3 hour 11", int'(tk_if.hour), 11);
    step(1'b1, 1'b0, 1'b1);
    chk("t3 hour wrap", int'(tk_if.hour), 0);
    chk("t3 ampm kept", int'(tk_if.am_pm), 0);
    step(1'b1, 1'b1, 1'b0);
    set_inc_n(58);
    chk("t3 min 59", int'(tk_if.min), 59);
    step(1'b1, 1'b0, 1'b1);
    chk("t3 min wrap", int'(tk_if.min), 0);
    chk("t3 hour kept", int'(tk_if.hour), 0);

    // 5: enter set mode at sec=30, prescaler=2.
    m_hour = 0; m_min = 0; m_sec = 0; m_ampm = 0;
    run_ticks(30, "t5 run");
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("t5 pre tick", int'(tk_if.sec_tick), 0);
    step(1'b1, 1'b0, 1'b0);
    chk("t5 sec cleared", int'(tk_if.sec), 0);
    chk("t5 set tick", int'(tk_if.sec_tick), 0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("t5 set tick hold", int'(tk_if.sec_tick), 0);
    end
    m_sec = 0;
    run_ticks(1, "t5 resume");

    // 6: reset mid-count at 05:17:42 PM, then reset mid-set with field 1.
    step(1'b1, 1'b0, 1'b0);
    set_inc_n(5);
    step(1'b1, 1'b1, 1'b0);
    set_inc_n(17);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("t6 field", int'(tk_if.set_field), 1);
    chk_time("t6 set", 5, 17, 0, 1);
    m_hour = 5; m_min = 17; m_sec = 0; m_ampm = 1;
    run_ticks(42, "t6 run");
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk_reset("t6 rst count");
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("t6 set field1", int'(tk_if.set_field), 1);
    chk("t6 set min1", int'(tk_if.min), 1);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    chk_reset("t6 rst set");
    rst = 1'b0;
    m_hour = 0; m_min = 0; m_sec = 0; m_ampm = 0;
    run_ticks(2, "t6 after rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
